// File: rtl/wired_rob_ring_pkg.sv
// Shared ROB types and helpers. The core-level ROB length follows the _WIRED_PARAM_ROB_LEN
// macro when the core defines it, otherwise 32 entries.
`ifndef _WIRED_PARAM_ROB_LEN
`define _WIRED_PARAM_ROB_LEN 32
`endif

package wired_rob_ring_pkg;

    localparam int unsigned RobLen     = `_WIRED_PARAM_ROB_LEN;
    localparam int unsigned RobRidW    = $clog2(RobLen);
    localparam int unsigned RobStaticW = 32;
    localparam int unsigned RobDataW   = 32;

    typedef logic [RobRidW-1:0]    rob_rid_t;
    typedef logic [RobStaticW-1:0] rob_static_t;
    typedef logic [RobDataW-1:0]   rob_data_t;

    typedef struct packed {
        logic occupied;
        logic done;
        logic excp;
    } rob_dynamic_t;

    function automatic logic [31:0] popcount(input logic [31:0] v);
        logic [31:0] c;
        c = '0;
        for (int i = 0; i < 32; i++) begin
            c = c + 32'(v[i]);
        end
        return c;
    endfunction

endpackage

// File: rtl/wired_registers_file_banked.sv
// Multi-write, multi-read register file with combinational reads. On a same-address
// collision the highest-numbered write port wins. Contents are not reset.
module wired_registers_file_banked #(
    parameter int unsigned DEPTH = 32,
    parameter int unsigned WIDTH = 32,
    parameter int unsigned NW    = 2,
    parameter int unsigned NR    = 2
) (
    input  logic                          clk,
    input  logic [NW-1:0]                 we,
    input  logic [NW*$clog2(DEPTH)-1:0]   waddr,
    input  logic [NW*WIDTH-1:0]           wdata,
    input  logic [NR*$clog2(DEPTH)-1:0]   raddr,
    output logic [NR*WIDTH-1:0]           rdata
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        for (int i = 0; i < NW; i++) begin
            if (we[i]) begin
                mem[waddr[i*AW +: AW]] <= wdata[i*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NR; i++) begin
            rdata[i*WIDTH +: WIDTH] = mem[raddr[i*AW +: AW]];
        end
    end

endmodule

// File: rtl/wired_rob_ring.sv
// Reorder buffer ring: in-order multi-lane dispatch and commit, out-of-order CDB completion.
// Define WIRED_ROB_EXCP_STOP_EN to present excepting entries on commit lane 0 only.
module wired_rob_ring
    import wired_rob_ring_pkg::*;
#(
    parameter int unsigned DEPTH    = RobLen,
    parameter int unsigned DISP_W   = 2,
    parameter int unsigned CDB_W    = 2,
    parameter int unsigned COMMIT_W = 2,
    parameter int unsigned SW       = 32,
    parameter int unsigned DW       = 32
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [DISP_W-1:0]                 d_valid_i,
    input  logic [DISP_W*SW-1:0]              d_info_i,
    output logic                              d_ready_o,
    output logic [DISP_W*$clog2(DEPTH)-1:0]   d_rid_o,
    input  logic [CDB_W-1:0]                  cdb_valid_i,
    input  logic [CDB_W*$clog2(DEPTH)-1:0]    cdb_rid_i,
    input  logic [CDB_W*DW-1:0]               cdb_data_i,
    input  logic [CDB_W-1:0]                  cdb_excp_i,
    output logic [COMMIT_W-1:0]               c_valid_o,
    output logic [COMMIT_W*$clog2(DEPTH)-1:0] c_rid_o,
    output logic [COMMIT_W*SW-1:0]            c_info_o,
    output logic [COMMIT_W*DW-1:0]            c_data_o,
    output logic [COMMIT_W-1:0]               c_excp_o,
    input  logic [COMMIT_W-1:0]               c_retire_i,
    input  logic                              flush_i,
    output logic [$clog2(DEPTH):0]            count_o,
    output logic                              empty_o,
    output logic                              full_o
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [PW-1:0]     head_q, head_d, tail_q, tail_d, count;
    logic [DEPTH-1:0]  occ_q, occ_d, done_q, done_d, excp_q;
    logic [31:0]       disp_n, ret_n;
    logic              disp_go;
    logic [DISP_W-1:0] info_we;
    logic [CDB_W-1:0]  cdb_hit;
    logic [AW-1:0]     d_idx [DISP_W];
    logic [AW-1:0]     c_idx [COMMIT_W];
    logic [AW-1:0]     w_idx [CDB_W];
    logic              lane_ok, run;

    // Wrap bit makes tail - head exact modulo 2*DEPTH, so full and empty are distinct.
    assign count     = tail_q - head_q;
    assign count_o   = count;
    assign empty_o   = (count == '0);
    assign full_o    = (count == PW'(DEPTH));
    assign disp_n    = popcount(32'(d_valid_i));
    assign ret_n     = popcount(32'(c_retire_i));
    assign d_ready_o = (32'(DEPTH) - 32'(count)) >= disp_n;
    assign disp_go   = d_ready_o && !flush_i;

    always_comb begin
        for (int i = 0; i < DISP_W; i++) begin
            d_idx[i]              = tail_q[AW-1:0] + AW'(i);
            d_rid_o[i*AW +: AW]   = d_idx[i];
            info_we[i]            = disp_go && d_valid_i[i];
        end
    end

    always_comb begin
        for (int i = 0; i < CDB_W; i++) begin
            w_idx[i]   = cdb_rid_i[i*AW +: AW];
            cdb_hit[i] = cdb_valid_i[i] && occ_q[w_idx[i]] && !flush_i;
        end
    end

    always_comb begin
        for (int i = 0; i < COMMIT_W; i++) begin
            c_idx[i]            = head_q[AW-1:0] + AW'(i);
            c_rid_o[i*AW +: AW] = c_idx[i];
            c_excp_o[i]         = excp_q[c_idx[i]];
        end
    end

    // Commit presentation uses only registered state, keeping cdb_* off this path.
    always_comb begin
        c_valid_o = '0;
        lane_ok   = 1'b0;
        run       = 1'b1;
        for (int i = 0; i < COMMIT_W; i++) begin
            lane_ok = occ_q[c_idx[i]] && done_q[c_idx[i]];
`ifdef WIRED_ROB_EXCP_STOP_EN
            if (i > 0) begin
                lane_ok = lane_ok && !excp_q[c_idx[i]] && !excp_q[c_idx[i] - AW'(1)];
            end
`endif
            run          = run && lane_ok;
            c_valid_o[i] = run;
        end
    end

    always_comb begin
        head_d = head_q + PW'(ret_n);
        tail_d = tail_q + (disp_go ? PW'(disp_n) : PW'(0));
        occ_d  = occ_q;
        done_d = done_q;
        for (int i = 0; i < COMMIT_W; i++) begin
            if (c_retire_i[i]) begin
                occ_d[c_idx[i]] = 1'b0;
            end
        end
        for (int i = 0; i < CDB_W; i++) begin
            if (cdb_hit[i]) begin
                done_d[w_idx[i]] = 1'b1;
            end
        end
        for (int i = 0; i < DISP_W; i++) begin
            if (info_we[i]) begin
                occ_d[d_idx[i]]  = 1'b1;
                done_d[d_idx[i]] = 1'b0;
            end
        end
        if (flush_i) begin
            head_d = '0;
            tail_d = '0;
            occ_d  = '0;
            done_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head_q <= '0;
            tail_q <= '0;
            occ_q  <= '0;
            done_q <= '0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            occ_q  <= occ_d;
            done_q <= done_d;
        end
    end

    // Exception flags are payload: written with the CDB result, never reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < CDB_W; i++) begin
            if (cdb_hit[i]) begin
                excp_q[w_idx[i]] <= cdb_excp_i[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && !flush_i) begin
            assert (((c_retire_i & ~c_valid_o) == '0) &&
                    ((c_retire_i & (c_retire_i + COMMIT_W'(1))) == '0))
                else $error("wired_rob_ring: illegal retire pattern %b (valid %b)",
                            c_retire_i, c_valid_o);
        end
    end

    wired_registers_file_banked #(
        .DEPTH (DEPTH),
        .WIDTH (SW),
        .NW    (DISP_W),
        .NR    (COMMIT_W)
    ) u_info (
        .clk   (clk),
        .we    (info_we),
        .waddr (d_rid_o),
        .wdata (d_info_i),
        .raddr (c_rid_o),
        .rdata (c_info_o)
    );

    wired_registers_file_banked #(
        .DEPTH (DEPTH),
        .WIDTH (DW),
        .NW    (CDB_W),
        .NR    (COMMIT_W)
    ) u_data (
        .clk   (clk),
        .we    (cdb_hit),
        .waddr (cdb_rid_i),
        .wdata (cdb_data_i),
        .raddr (c_rid_o),
        .rdata (c_data_o)
    );

endmodule

// File: tb/tb_wired_rob_ring.sv
// Directed bench for wired_rob_ring at DEPTH=8 with a commit scoreboard fed at dispatch.
// Build with WIRED_ROB_EXCP_STOP_EN defined to exercise the exception-stop presentation.
module tb_wired_rob_ring;
    localparam int unsigned DEPTH    = 8;
    localparam int unsigned DISP_W   = 2;
    localparam int unsigned CDB_W    = 2;
    localparam int unsigned COMMIT_W = 2;
    localparam int unsigned SW       = 32;
    localparam int unsigned DW       = 32;
    localparam int unsigned AW       = 3;

    typedef struct {
        int          rid;
        logic [31:0] info;
        logic [31:0] data;
    } exp_t;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic [DISP_W-1:0]      d_valid_i;
    logic [DISP_W*SW-1:0]   d_info_i;
    logic                   d_ready_o;
    logic [DISP_W*AW-1:0]   d_rid_o;
    logic [CDB_W-1:0]       cdb_valid_i;
    logic [CDB_W*AW-1:0]    cdb_rid_i;
    logic [CDB_W*DW-1:0]    cdb_data_i;
    logic [CDB_W-1:0]       cdb_excp_i;
    logic [COMMIT_W-1:0]    c_valid_o;
    logic [COMMIT_W*AW-1:0] c_rid_o;
    logic [COMMIT_W*SW-1:0] c_info_o;
    logic [COMMIT_W*DW-1:0] c_data_o;
    logic [COMMIT_W-1:0]    c_excp_o;
    logic [COMMIT_W-1:0]    c_retire_i;
    logic                   flush_i;
    logic [AW:0]            count_o;
    logic                   empty_o;
    logic                   full_o;

    exp_t        exp_q [$];
    int          mcount, mtail, seq;
    int          slot_seq [DEPTH];
    bit          slot_excp [DEPTH];
    bit          slot_done [DEPTH];
    logic [1:0]  ret_mask;
    bit          last_acc;
    int          vectors, miscompares;

    always #5 clk = ~clk;

    wired_rob_ring #(
        .DEPTH    (DEPTH),
        .DISP_W   (DISP_W),
        .CDB_W    (CDB_W),
        .COMMIT_W (COMMIT_W),
        .SW       (SW),
        .DW       (DW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .d_valid_i   (d_valid_i),
        .d_info_i    (d_info_i),
        .d_ready_o   (d_ready_o),
        .d_rid_o     (d_rid_o),
        .cdb_valid_i (cdb_valid_i),
        .cdb_rid_i   (cdb_rid_i),
        .cdb_data_i  (cdb_data_i),
        .cdb_excp_i  (cdb_excp_i),
        .c_valid_o   (c_valid_o),
        .c_rid_o     (c_rid_o),
        .c_info_o    (c_info_o),
        .c_data_o    (c_data_o),
        .c_excp_o    (c_excp_o),
        .c_retire_i  (c_retire_i),
        .flush_i     (flush_i),
        .count_o     (count_o),
        .empty_o     (empty_o),
        .full_o      (full_o)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic set_disp(input int n);
        d_valid_i = (n >= 2) ? 2'b11 : ((n == 1) ? 2'b01 : 2'b00);
        d_info_i  = {32'hA000_0000 + 32'(seq + 1), 32'hA000_0000 + 32'(seq)};
    endtask

    task automatic set_cdb(input int port, input int rid, input bit ex, input bit bad);
        cdb_valid_i[port]          = 1'b1;
        cdb_rid_i[port*AW +: AW]   = AW'(rid);
        cdb_data_i[port*DW +: DW]  = bad ? 32'hBAD0_0000 : 32'hD000_0000 + 32'(slot_seq[rid]);
        cdb_excp_i[port]           = ex;
        if (!bad) begin
            slot_excp[rid] = ex;
            slot_done[rid] = 1'b1;
        end
    endtask

    // Checks the dispatch handshake and pushes accepted entries into the scoreboard.
    task automatic issue();
        int n;
        bit acc;
        int rid;
        #1;
        n   = int'(d_valid_i[0]) + int'(d_valid_i[1]);
        acc = (int'(DEPTH) - mcount) >= n;
        chk("d_ready", 64'(d_ready_o), 64'(acc));
        for (int i = 0; i < DISP_W; i++) begin
            chk("d_rid", 64'(d_rid_o[i*AW +: AW]), 64'((mtail + i) % int'(DEPTH)));
        end
        if (!rst_n || flush_i) begin
            mcount   = 0;
            mtail    = 0;
            last_acc = 1'b0;
            exp_q.delete();
        end else begin
            last_acc = acc && (n > 0);
            if (last_acc) begin
                for (int i = 0; i < n; i++) begin
                    rid            = (mtail + i) % int'(DEPTH);
                    slot_seq[rid]  = seq;
                    slot_done[rid] = 1'b0;
                    exp_q.push_back('{rid, d_info_i[i*SW +: SW], 32'hD000_0000 + 32'(seq)});
                    seq++;
                end
                mcount = mcount + n;
                mtail  = (mtail + n) % int'(DEPTH);
            end
        end
    endtask

    task automatic cyc();
        issue();
        @(negedge clk);
        d_valid_i   = '0;
        cdb_valid_i = '0;
        cdb_excp_i  = '0;
        flush_i     = 1'b0;
        ret_mask    = '0;
    endtask

    // Streams `total` dispatches while completing and retiring everything, until empty.
    task automatic run_flow(input int total, input int budget);
        int remaining;
        int cycles;
        int port;
        int want;
        remaining = total;
        cycles    = 0;
        while ((remaining > 0 || mcount > 0) && cycles < budget) begin
            chk("flow_count", 64'(count_o), 64'(mcount));
            chk("flow_full", 64'(full_o), 64'(mcount == int'(DEPTH)));
            want = (remaining >= 2) ? 2 : remaining;
            if (want > 0) set_disp(want);
            port = 0;
            foreach (exp_q[k]) begin
                if (port < int'(CDB_W) && !slot_done[exp_q[k].rid]) begin
                    set_cdb(port, exp_q[k].rid, 1'b0, 1'b0);
                    port++;
                end
            end
            ret_mask = 2'b11;
            cyc();
            if (last_acc) remaining = remaining - want;
            cycles++;
        end
        chk("flow_done", 64'(remaining + mcount), 64'(0));
    endtask

    // Commit monitor: retires what the stimulus allows and compares against the scoreboard.
    initial begin
        exp_t e;
        c_retire_i = '0;
        forever begin
            @(negedge clk);
            #2;
            c_retire_i = (rst_n && !flush_i) ? (c_valid_o & ret_mask) : '0;
            for (int i = 0; i < COMMIT_W; i++) begin
                if (c_retire_i[i]) begin
                    if (exp_q.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL commit_unexpected: got rid %0d, expected no commit",
                                 c_rid_o[i*AW +: AW]);
                    end else begin
                        e = exp_q.pop_front();
                        chk("c_rid", 64'(c_rid_o[i*AW +: AW]), 64'(e.rid));
                        chk("c_info", 64'(c_info_o[i*SW +: SW]), 64'(e.info));
                        chk("c_data", 64'(c_data_o[i*DW +: DW]), 64'(e.data));
                        chk("c_excp", 64'(c_excp_o[i]), 64'(slot_excp[e.rid]));
                        mcount--;
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish before 200us");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n       = 1'b0;
        d_valid_i   = '0;
        d_info_i    = '0;
        cdb_valid_i = '0;
        cdb_rid_i   = '0;
        cdb_data_i  = '0;
        cdb_excp_i  = '0;
        flush_i     = 1'b0;
        ret_mask    = '0;
        mcount      = 0;
        mtail       = 0;
        seq         = 0;
        vectors     = 0;
        miscompares = 0;
        last_acc    = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        chk("rst_c_valid", 64'(c_valid_o), 64'(0));
        chk("rst_empty", 64'(empty_o), 64'(1));
        chk("rst_full", 64'(full_o), 64'(0));
        chk("rst_count", 64'(count_o), 64'(0));
        chk("rst_d_ready", 64'(d_ready_o), 64'(1));
        chk("rst_d_rid", 64'(d_rid_o), 64'(6'b001_000));

        // Two-wide dispatch, then out-of-order completion.
        set_disp(2);
        cyc();
        chk("disp2_count", 64'(count_o), 64'(2));
        chk("disp2_c_valid", 64'(c_valid_o), 64'(0));
        set_cdb(0, 1, 1'b0, 1'b0);
        cyc();
        chk("cdb_rid1_c_valid", 64'(c_valid_o), 64'(2'b00));
        set_cdb(1, 0, 1'b0, 1'b0);
        cyc();
        chk("cdb_rid0_c_valid", 64'(c_valid_o), 64'(2'b11));
        ret_mask = 2'b11;
        cyc();
        chk("retire2_empty", 64'(empty_o), 64'(1));
        chk("retire2_count", 64'(count_o), 64'(0));

        // CDB to a slot being dispatched this cycle is ignored; higher port wins a collision.
        set_disp(2);
        set_cdb(0, 2, 1'b0, 1'b1);
        cyc();
        chk("cdb_unocc_c_valid", 64'(c_valid_o), 64'(2'b00));
        set_cdb(0, 2, 1'b1, 1'b1);
        set_cdb(1, 2, 1'b0, 1'b0);
        cyc();
        chk("cdb_prio_c_valid", 64'(c_valid_o), 64'(2'b01));
        set_cdb(0, 3, 1'b0, 1'b0);
        ret_mask = 2'b01;
        cyc();
        chk("retire1_c_valid", 64'(c_valid_o), 64'(2'b01));
        chk("retire1_count", 64'(count_o), 64'(1));
        ret_mask = 2'b01;
        cyc();
        chk("retire1b_empty", 64'(empty_o), 64'(1));

        // Fill to 7 of 8, then over-ask with and without a same-cycle retire.
        set_disp(2); cyc();
        set_disp(2); cyc();
        set_disp(2); cyc();
        set_disp(1); cyc();
        chk("fill7_count", 64'(count_o), 64'(7));
        chk("fill7_full", 64'(full_o), 64'(0));
        set_disp(2);
        cyc();
        chk("reject_count", 64'(count_o), 64'(7));
        set_cdb(0, exp_q[0].rid, 1'b0, 1'b0);
        cyc();
        chk("head_done_c_valid", 64'(c_valid_o), 64'(2'b01));
        set_disp(2);
        ret_mask = 2'b01;
        cyc();
        chk("reject_retire_count", 64'(count_o), 64'(6));
        set_disp(2);
        cyc();
        chk("fill8_count", 64'(count_o), 64'(8));
        chk("fill8_full", 64'(full_o), 64'(1));
        chk("fill8_empty", 64'(empty_o), 64'(0));
        set_disp(1);
        cyc();
        chk("full_hold", 64'(full_o), 64'(1));
        run_flow(0, 40);

        // Twenty entries streamed through, wrapping the ids.
        run_flow(20, 100);
        chk("wrap_empty", 64'(empty_o), 64'(1));

        // Flush wins over dispatch and CDB in the same cycle.
        set_disp(2); cyc();
        set_disp(2); cyc();
        set_disp(1); cyc();
        chk("pre_flush_count", 64'(count_o), 64'(5));
        set_disp(2);
        set_cdb(0, exp_q[0].rid, 1'b0, 1'b0);
        flush_i  = 1'b1;
        ret_mask = 2'b11;
        cyc();
        chk("flush_count", 64'(count_o), 64'(0));
        chk("flush_c_valid", 64'(c_valid_o), 64'(0));
        chk("flush_d_rid0", 64'(d_rid_o[AW-1:0]), 64'(0));
        chk("flush_empty", 64'(empty_o), 64'(1));

        // Reset in the middle of operation discards everything.
        set_disp(2); cyc();
        set_disp(1); cyc();
        set_cdb(0, exp_q[0].rid, 1'b0, 1'b0);
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        chk("midrst_count", 64'(count_o), 64'(0));
        chk("midrst_c_valid", 64'(c_valid_o), 64'(0));
        chk("midrst_d_rid", 64'(d_rid_o), 64'(6'b001_000));

        // Exception on head+1.
        set_disp(2);
        cyc();
        set_cdb(0, 0, 1'b0, 1'b0);
        set_cdb(1, 1, 1'b1, 1'b0);
        cyc();
`ifdef WIRED_ROB_EXCP_STOP_EN
        chk("excp_c_valid", 64'(c_valid_o), 64'(2'b01));
`else
        chk("excp_c_valid", 64'(c_valid_o), 64'(2'b11));
`endif
        ret_mask = 2'b01;
        cyc();
        chk("excp_lane0_valid", 64'(c_valid_o), 64'(2'b01));
        chk("excp_lane0_flag", 64'(c_excp_o[0]), 64'(1));
        chk("excp_lane0_rid", 64'(c_rid_o[AW-1:0]), 64'(1));
        ret_mask = 2'b01;
        cyc();
        chk("excp_empty", 64'(empty_o), 64'(1));

        repeat (2) @(negedge clk);
        chk("scoreboard_drained", 64'(exp_q.size()), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
